// File: rtl/sram_port_arbiter_pkg.sv
// Shared constants for the two-port SRAM arbiter: FSM states, grant codes,
// arbitration modes and the round-robin "last owner" encoding.
package sram_port_arbiter_pkg;
  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_BUSY = 1'b1;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_D    = 2'b01;
  localparam logic [1:0] GNT_I    = 2'b10;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  localparam logic RR_D = 1'b0;
  localparam logic RR_I = 1'b1;
endpackage

// File: rtl/sram_arb_picker.sv
// Combinational winner selection between port D and port I.
module sram_arb_picker
  import sram_port_arbiter_pkg::*;
#(
  parameter int RR_MODE      = ARB_FIXED,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             req_d,
  input  logic             req_i,
  input  logic             rr_last,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic [1:0]       pick,
  output logic             starve_force
);

  always_comb begin
    pick         = GNT_NONE;
    starve_force = 1'b0;
    if (req_d && req_i) begin
      if (RR_MODE == ARB_RR) begin
        pick = (rr_last == RR_I) ? GNT_D : GNT_I;
      end else if (starve_cnt == CNT_W'(STARVE_LIMIT)) begin
        pick         = GNT_I;
        starve_force = 1'b1;
      end else begin
        pick = GNT_D;
      end
    end else if (req_d) begin
      pick = GNT_D;
    end else if (req_i) begin
      pick = GNT_I;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SramController between the data cache (port D) and the
// instruction cache (port I); one access at a time, operands latched at grant.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int WDATA_W      = 32,
  parameter int RDATA_W      = 64,
  parameter int RR_MODE      = ARB_FIXED,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               d_rd_en,
  input  logic               d_wr_en,
  input  logic [ADDR_W-1:0]  d_address,
  input  logic [WDATA_W-1:0] d_w_data,
  output logic [RDATA_W-1:0] d_r_data,
  output logic               d_ready,
  input  logic               i_rd_en,
  input  logic               i_wr_en,
  input  logic [ADDR_W-1:0]  i_address,
  input  logic [WDATA_W-1:0] i_w_data,
  output logic [RDATA_W-1:0] i_r_data,
  output logic               i_ready,
  output logic               sram_rd_en,
  output logic               sram_wr_en,
  output logic [ADDR_W-1:0]  sram_address,
  output logic [WDATA_W-1:0] sram_w_data,
  input  logic [RDATA_W-1:0] sram_r_data,
  input  logic               sram_ready,
  output logic [1:0]         grant,
  output logic               busy
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [0:0]         state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WDATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]   starve_q, starve_d;
  logic               rr_last_q, rr_last_d;

  logic       req_d, req_i;
  logic [1:0] pick;
  logic       starve_force;

  assign req_d = d_rd_en | d_wr_en;
  assign req_i = i_rd_en | i_wr_en;

  sram_arb_picker #(
    .RR_MODE      (RR_MODE),
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_picker (
    .req_d        (req_d),
    .req_i        (req_i),
    .rr_last      (rr_last_q),
    .starve_cnt   (starve_q),
    .pick         (pick),
    .starve_force (starve_force)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    starve_d  = starve_q;
    rr_last_d = rr_last_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick != GNT_NONE) begin
          state_d   = ARB_BUSY;
          grant_d   = pick;
          rr_last_d = (pick == GNT_D) ? RR_D : RR_I;
          if (pick == GNT_D) begin
            wr_d    = d_wr_en;
            addr_d  = d_address;
            wdata_d = d_w_data;
          end else begin
            wr_d    = i_wr_en;
            addr_d  = i_address;
            wdata_d = i_w_data;
          end
          // Count only D grants that made a waiting I lose; saturate at the limit.
          if (RR_MODE == ARB_RR || starve_force || pick == GNT_I || !req_i)
            starve_d = '0;
          else if (starve_q != CNT_W'(STARVE_LIMIT))
            starve_d = starve_q + CNT_W'(1);
        end
      end
      default: begin
        if (sram_ready) begin
          state_d = ARB_IDLE;
          grant_d = GNT_NONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      grant_q   <= GNT_NONE;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      starve_q  <= '0;
      rr_last_q <= RR_I;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      starve_q  <= starve_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign busy         = (state_q == ARB_BUSY);
  assign grant        = grant_q;
  assign sram_rd_en   = busy & ~wr_q;
  assign sram_wr_en   = busy & wr_q;
  assign sram_address = busy ? addr_q : '0;
  assign sram_w_data  = busy ? wdata_q : '0;

  // An idle port reads as ready so a cache with nothing pending never stalls.
  assign d_ready  = ~rst & (~req_d | (busy & grant_q[0] & sram_ready));
  assign i_ready  = ~rst & (~req_i | (busy & grant_q[1] & sram_ready));
  assign d_r_data = sram_r_data;
  assign i_r_data = sram_r_data;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench: instance 0 runs fixed priority, instance 1 round-robin,
// each with its own variable-latency SRAM model.
module tb_sram_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic d_rd_en, d_wr_en, i_rd_en, i_wr_en;
  logic [31:0] d_address, d_w_data, i_address, i_w_data;

  logic [1:0][63:0] d_r_data, i_r_data, sram_r_data;
  logic [1:0]       d_ready, i_ready, sram_rd_en, sram_wr_en, sram_ready, busy;
  logic [1:0][31:0] sram_address, sram_w_data;
  logic [1:0][1:0]  grant;

  int lat = 5;
  int ntests = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_inst
    int cnt;
    sram_port_arbiter #(.ADDR_W(32), .WDATA_W(32), .RDATA_W(64),
                        .RR_MODE(k), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .d_rd_en(d_rd_en), .d_wr_en(d_wr_en), .d_address(d_address), .d_w_data(d_w_data),
      .d_r_data(d_r_data[k]), .d_ready(d_ready[k]),
      .i_rd_en(i_rd_en), .i_wr_en(i_wr_en), .i_address(i_address), .i_w_data(i_w_data),
      .i_r_data(i_r_data[k]), .i_ready(i_ready[k]),
      .sram_rd_en(sram_rd_en[k]), .sram_wr_en(sram_wr_en[k]),
      .sram_address(sram_address[k]), .sram_w_data(sram_w_data[k]),
      .sram_r_data(sram_r_data[k]), .sram_ready(sram_ready[k]),
      .grant(grant[k]), .busy(busy[k])
    );
    always @(posedge clk) begin
      if (rst || !(sram_rd_en[k] || sram_wr_en[k]) || sram_ready[k]) cnt <= 0;
      else cnt <= cnt + 1;
    end
    assign sram_ready[k]  = (sram_rd_en[k] || sram_wr_en[k]) && (cnt == lat - 1);
    assign sram_r_data[k] = 64'h1122334455667788;
  end

  task automatic test_reset();
    logic exp;
    rst = 1'b1;
    d_rd_en = 0; d_wr_en = 0; i_rd_en = 0; i_wr_en = 0;
    d_address = 0; d_w_data = 0; i_address = 0; i_w_data = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ntests++; if (grant[0] !== 2'b00) begin nfail++; $display("FAIL reset_grant got %b want 00", grant[0]); end
    ntests++; if (busy[0] !== 1'b0) begin nfail++; $display("FAIL reset_busy got %b want 0", busy[0]); end
    ntests++; if (sram_rd_en[0] !== 1'b0 || sram_wr_en[0] !== 1'b0) begin nfail++; $display("FAIL reset_en got %b%b want 00", sram_rd_en[0], sram_wr_en[0]); end
    ntests++; if (sram_address[0] !== 32'h0) begin nfail++; $display("FAIL reset_addr got %h want 0", sram_address[0]); end
    ntests++; if (d_ready[0] !== 1'b0 || i_ready[0] !== 1'b0) begin nfail++; $display("FAIL reset_ready_in_rst got %b%b want 00", d_ready[0], i_ready[0]); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    ntests++; if (d_ready[0] !== 1'b1 || i_ready[0] !== 1'b1) begin nfail++; $display("FAIL idle_ready got %b%b want 11", d_ready[0], i_ready[0]); end
    // Start a D read and kill it mid-access with an asynchronous reset.
    @(posedge clk); #1 d_rd_en = 1; d_address = 32'h44;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    ntests++; if (grant[0] !== 2'b00) begin nfail++; $display("FAIL midrst_grant got %b want 00", grant[0]); end
    ntests++; if (sram_rd_en[0] !== 1'b0) begin nfail++; $display("FAIL midrst_rd_en got %b want 0", sram_rd_en[0]); end
    ntests++; if (d_ready[0] !== 1'b0) begin nfail++; $display("FAIL midrst_d_ready got %b want 0", d_ready[0]); end
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      exp = (c == 5);
      ntests++; if (d_ready[0] !== exp) begin nfail++; $display("FAIL postrst_d_ready cyc %0d got %b want %b", c, d_ready[0], exp); end
    end
    @(posedge clk); #1 d_rd_en = 0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    logic exp;
    @(posedge clk); #1 d_rd_en = 1; d_address = 32'h400;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      exp = (c == 5);
      ntests++; if (d_ready[0] !== exp) begin nfail++; $display("FAIL read_d_ready cyc %0d got %b want %b", c, d_ready[0], exp); end
      ntests++; if (i_ready[0] !== 1'b1) begin nfail++; $display("FAIL read_i_ready cyc %0d got %b want 1", c, i_ready[0]); end
      if (c >= 1) begin
        ntests++; if (sram_address[0] !== 32'h400 || sram_rd_en[0] !== 1'b1 || sram_wr_en[0] !== 1'b0) begin
          nfail++; $display("FAIL read_sram cyc %0d got addr %h rd %b wr %b want 400 1 0", c, sram_address[0], sram_rd_en[0], sram_wr_en[0]);
        end
      end
      if (c == 5) begin
        ntests++; if (d_r_data[0] !== 64'h1122334455667788) begin nfail++; $display("FAIL read_data got %h want 1122334455667788", d_r_data[0]); end
      end
    end
    @(posedge clk); #1 d_rd_en = 0;
    @(negedge clk);
    ntests++; if (grant[0] !== 2'b00 || d_ready[0] !== 1'b1) begin nfail++; $display("FAIL read_after got grant %b rdy %b want 00 1", grant[0], d_ready[0]); end
  endtask

  task automatic test_write_latched();
    logic exp;
    @(posedge clk); #1 i_wr_en = 1; i_address = 32'h20; i_w_data = 32'hDEADBEEF;
    @(posedge clk); #1 i_address = 32'h0; i_w_data = 32'h0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      exp = (c == 5);
      ntests++; if (i_ready[0] !== exp) begin nfail++; $display("FAIL write_i_ready cyc %0d got %b want %b", c, i_ready[0], exp); end
      ntests++; if (sram_address[0] !== 32'h20 || sram_w_data[0] !== 32'hDEADBEEF || sram_wr_en[0] !== 1'b1 || sram_rd_en[0] !== 1'b0) begin
        nfail++; $display("FAIL write_sram cyc %0d got %h/%h wr %b rd %b want 20/deadbeef 1 0", c, sram_address[0], sram_w_data[0], sram_wr_en[0], sram_rd_en[0]);
      end
      if (c < 5) @(posedge clk);
    end
    @(posedge clk); #1 i_wr_en = 0;
    @(negedge clk);
  endtask

  task automatic test_dual_enable();
    logic exp;
    @(posedge clk); #1 d_rd_en = 1; d_wr_en = 1; d_address = 32'h88; d_w_data = 32'h5A5A;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      exp = (c == 5);
      ntests++; if (d_ready[0] !== exp) begin nfail++; $display("FAIL dual_d_ready cyc %0d got %b want %b", c, d_ready[0], exp); end
      if (c == 1) begin
        ntests++; if (sram_wr_en[0] !== 1'b1 || sram_rd_en[0] !== 1'b0) begin nfail++; $display("FAIL dual_en got wr %b rd %b want 1 0", sram_wr_en[0], sram_rd_en[0]); end
      end
    end
    @(posedge clk); #1 d_rd_en = 0; d_wr_en = 0;
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    logic [1:0] exp_fx [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    logic [1:0] got [2][10];
    int n [2];
    int idle [2];
    logic [1:0] pb;
    logic [1:0] exp_rr;
    n = '{0, 0}; idle = '{0, 0}; pb = 2'b00;
    @(posedge clk); #1 rst = 1'b1; lat = 2;
    @(posedge clk); #1 rst = 1'b0; d_rd_en = 1; i_rd_en = 1;
    for (int cyc = 0; cyc < 200 && (n[0] < 10 || n[1] < 10); cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (busy[k] && !pb[k]) begin
          if (n[k] < 10) got[k][n[k]] = grant[k];
          if (k == 1 && n[k] > 0 && n[k] < 10) begin
            ntests++; if (idle[k] != 1) begin nfail++; $display("FAIL rr_idle_gap grant %0d got %0d idle cycles want 1", n[k], idle[k]); end
          end
          n[k]++;
          idle[k] = 0;
        end else if (!busy[k]) begin
          idle[k]++;
        end
      end
      pb = busy;
    end
    ntests++; if (n[0] < 10 || n[1] < 10) begin nfail++; $display("FAIL arb_timeout got %0d/%0d grants want 10/10", n[0], n[1]); end
    for (int g = 0; g < 10; g++) begin
      if (g < n[0]) begin
        ntests++; if (got[0][g] !== exp_fx[g]) begin nfail++; $display("FAIL fixed_grant %0d got %b want %b", g, got[0][g], exp_fx[g]); end
      end
      if (g < n[1]) begin
        exp_rr = (g % 2 == 0) ? 2'b01 : 2'b10;
        ntests++; if (got[1][g] !== exp_rr) begin nfail++; $display("FAIL rr_grant %0d got %b want %b", g, got[1][g], exp_rr); end
      end
    end
    @(posedge clk); #1 d_rd_en = 0; i_rd_en = 0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_latched();
    test_dual_enable();
    test_arbitration();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single SramController instance between two requesters:
  - the data-side cache controller (port D);
  - an instruction-fetch cache (port I).
- Sits between both cache controllers and SramController.
- Each requester port presents the same enable/address/data/ready handshake the caches already use towards SRAM, so either cache plugs in unchanged.
- Sequences one SRAM access at a time and pulses the ready of the winning port on completion.

Parameters:
- ADDR_W, 32, request/SRAM address width
- WDATA_W, 32, write data width
- RDATA_W, 64, read line width returned by SramController
- RR_MODE, 0, 0 = fixed priority with D first; 1 = round-robin
- STARVE_LIMIT, 4, fixed-priority mode only: max consecutive D grants while I waits before I is forced

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- d_rd_en  in  1  port D read request
- d_wr_en  in  1  port D write request
- d_address  in  ADDR_W  port D address
- d_w_data  in  WDATA_W  port D write data
- d_r_data  out  RDATA_W  port D read data, valid only in the d_ready completion cycle
- d_ready  out  1  port D ready
- i_rd_en  in  1  port I read request
- i_wr_en  in  1  port I write request
- i_address  in  ADDR_W  port I address
- i_w_data  in  WDATA_W  port I write data
- i_r_data  out  RDATA_W  port I read data, valid only in the i_ready completion cycle
- i_ready  out  1  port I ready
- sram_rd_en  out  1  to SramController rd_en
- sram_wr_en  out  1  to SramController wr_en
- sram_address  out  ADDR_W  to SramController address
- sram_w_data  out  WDATA_W  to SramController write_data
- sram_r_data  in  RDATA_W  from SramController read_data
- sram_ready  in  1  from SramController ready; high together with an asserted enable means the access completes this cycle
- grant  out  2  one-hot owner of the SRAM; 01 = D, 10 = I, 00 = none
- busy  out  1  high in BUSY state

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values and effect:
  - state = IDLE;
  - sram_rd_en = sram_wr_en = 0, sram_address = 0, sram_w_data = 0;
  - grant = 00, busy = 0;
  - starve_cnt = 0, rr_last = I, so D wins first in RR mode.
- Reset mid-access: the access is abandoned immediately, with no ready pulse. SramController shares rst.
- Port request: req_X = X_rd_en | X_wr_en. If both rd_en and wr_en are high on the same port, the access is treated as a write.
- Port ready (combinational):
  - X_ready = 1 when req_X = 0;
  - otherwise X_ready = (state == BUSY) & grant[X] & sram_ready;
  - X_ready = 0 while rst is high.
- Read data: d_r_data = i_r_data = sram_r_data, passed straight through with no register.
- IDLE state:
  - If any req is high, pick a winner (see Arbitration).
  - Register the winner's op, address and w_data into holding registers.
  - Set grant and go to BUSY on the next edge.
  - If no req is high, stay in IDLE with grant = 00.
- BUSY state:
  - Drive sram_* from the holding registers. Later changes on the requester's inputs are ignored.
  - When sram_ready = 1: pulse the owner's ready that cycle, then go to IDLE on the next edge with grant cleared.
  - The losing port keeps X_ready = 0 throughout.
- Arbitration, fixed mode (RR_MODE = 0):
  - D wins when both request, unless starve_cnt == STARVE_LIMIT, in which case I wins and starve_cnt clears.
  - starve_cnt increments when D is granted while req_I is high.
  - starve_cnt clears on any I grant, or on a D grant while req_I is low.
  - starve_cnt saturates at STARVE_LIMIT.
- Arbitration, round-robin mode (RR_MODE = 1):
  - When both request, the port other than rr_last wins.
  - rr_last updates on every grant.
  - starve_cnt is unused and held at 0.
- Latency:
  - minimum 1 arbitration cycle + SRAM latency;
  - back-to-back accesses from alternating ports leave one IDLE cycle between accesses;
  - a port re-requesting in the cycle after its completion counts as a new request.
- Requester obligation: hold the request until ready is seen. A request dropped before completion is illegal while BUSY; the access still completes and the ready pulse is dropped.

Decomposition:
- Shared defines file holds:
  - state encodings ARB_IDLE = 1'b0 and ARB_BUSY = 1'b1;
  - grant codes GNT_NONE / GNT_D / GNT_I;
  - mode constants ARB_FIXED / ARB_RR.
- One sub-module, sram_arb_picker: combinational winner selection from req_D, req_I, rr_last, starve_cnt and RR_MODE. Outputs are a one-hot pick and a starve-force flag.
- FSM, holding registers and muxing stay in the top module.

Test Plan:
- Reset state: rst pulsed mid-BUSY -> grant = 00, sram_rd_en = 0, no ready pulse; with d_rd_en = 1 held, d_ready stays 0 until the next grant completes.
- Single read: d_rd_en = 1, d_address = 0x400, SRAM model with 5-cycle latency returning 0x1122334455667788 -> sram_address = 0x400 from cycle 1, d_ready = 1 for exactly one cycle with d_r_data = 0x1122334455667788, i_ready = 1 throughout.
- Write with latched operands: i_wr_en = 1, i_address = 0x20, i_w_data = 0xDEADBEEF, inputs changed to 0x0 the cycle after the grant -> SRAM sees 0x20 / 0xDEADBEEF until completion, i_ready pulses once.
- Fixed-priority starvation: RR_MODE = 0, STARVE_LIMIT = 4, D and I requesting continuously -> grant sequence D, D, D, D, I, D, D, D, D, I.
- Round-robin: RR_MODE = 1, both requesting continuously -> grants alternate D, I, D, I; every completion is separated by one IDLE cycle.
- Dual-enable write: d_rd_en = d_wr_en = 1 -> sram_wr_en = 1, sram_rd_en = 0.
